// File: rtl/pp_buffer_gen.sv
// Two-bank ping-pong buffer between a streaming producer and a back-pressured
// consumer. The writer fills one bank while the reader drains the other. A bank
// becomes readable when the writer closes it, either by filling it or with
// in_last. It becomes writable again once the reader has emitted its last word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word on in
//   in_ready   buffer accepts a word this cycle (write bank not full)
//   in         write data
//   in_last    closes the current write bank after this word
//   out_valid  out holds a valid word
//   busy       consumer stall; out holds while out_valid && busy
//   out        registered read data
//   out_last   out is the final word of its bank
//   bank_full  per-bank closed/readable flag, bit i = bank i
module pp_buffer_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              busy,
  output logic [DATA_W-1:0] out,
  output logic              out_last,
  output logic [1:0]        bank_full
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [2][DEPTH];

  logic              wsel_q, rsel_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [ADDR_W:0]   len_q [2];
  logic [1:0]        bank_full_q, bank_full_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_q;
  logic              out_last_q;

  logic              wr_en, wr_close;
  logic              rd_free, rd_en, rd_is_last, rd_close;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    in_ready   = ~bank_full_q[wsel_q];
    wr_en      = in_valid & in_ready;
    wr_close   = wr_en & (in_last | (waddr_q == LastAddr));
    rd_free    = ~out_valid_q | ~busy;
    rd_en      = bank_full_q[rsel_q] & rd_free;
    rd_is_last = ({1'b0, raddr_q} == (len_q[rsel_q] - LenOne));
    rd_close   = rd_en & rd_is_last;
    rd_data    = mem[rsel_q][raddr_q];
  end

  // Writer only closes a non-full bank and reader only frees a full one, so the
  // two updates never target the same bit in one cycle.
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_close) bank_full_d[wsel_q] = 1'b1;
    if (rd_close) bank_full_d[rsel_q] = 1'b0;
  end

  // Storage is not reset; bank_full gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wsel_q][waddr_q] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel_q      <= 1'b0;
      waddr_q     <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      bank_full_q <= 2'b00;
    end else begin
      bank_full_q <= bank_full_d;
      if (wr_en) begin
        if (wr_close) begin
          len_q[wsel_q] <= {1'b0, waddr_q} + LenOne;
          waddr_q       <= '0;
          wsel_q        <= ~wsel_q;
        end else begin
          waddr_q <= waddr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsel_q      <= 1'b0;
      raddr_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
    end else if (rd_en) begin
      out_q       <= rd_data;
      out_valid_q <= 1'b1;
      out_last_q  <= rd_is_last;
      if (rd_is_last) begin
        raddr_q <= '0;
        rsel_q  <= ~rsel_q;
      end else begin
        raddr_q <= raddr_q + 1'b1;
      end
    end else if (rd_free) begin
      // Nothing to read: drop valid, keep the last data word on out.
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_last  = out_last_q;
  assign bank_full = bank_full_q;

endmodule

// File: tb/tb_pp_buffer_gen.sv
module tb_pp_buffer_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              busy;
  logic [DATA_W-1:0] out;
  logic              out_last;
  logic [1:0]        bank_full;

  pp_buffer_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .busy     (busy),
    .out      (out),
    .out_last (out_last),
    .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words of the open bank, then readable words of closed
  // banks ({last, data}) in order, plus the bank id of each closed bank.
  logic [8:0] open_q[$];
  logic [8:0] ready_q[$];
  bit         ids_q[$];
  bit         wbank;
  logic       m_ov, m_ol;
  logic [7:0] m_out;

  // Source words for the producer: {last, data}.
  logic [8:0] src_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_bf();
    logic [1:0] bf = 2'b00;
    foreach (ids_q[i]) bf[ids_q[i]] = 1'b1;
    return bf;
  endfunction

  task automatic model_reset();
    open_q.delete();
    ready_q.delete();
    ids_q.delete();
    wbank = 1'b0;
    m_ov  = 1'b0;
    m_ol  = 1'b0;
    m_out = 8'h00;
  endtask

  // One clock: called just after a falling edge, returns at the next one.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic b,
                       output bit acc);
    logic [8:0] w;
    bit         rdy;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    busy     = b;
    #1;
    rdy = (ids_q.size() < 2);
    check("in_ready", in_ready, rdy);
    check("bank_full", bank_full, model_bf());
    @(posedge clk);
    if (!m_ov || !b) begin
      if (ready_q.size() > 0) begin
        w     = ready_q.pop_front();
        m_ov  = 1'b1;
        m_out = w[7:0];
        m_ol  = w[8];
        if (w[8]) void'(ids_q.pop_front());
      end else begin
        m_ov = 1'b0;
        m_ol = 1'b0;
      end
    end
    acc = v && rdy;
    if (acc) begin
      if (l || open_q.size() == DEPTH - 1) begin
        foreach (open_q[i]) ready_q.push_back(open_q[i]);
        ready_q.push_back({1'b1, d});
        open_q.delete();
        ids_q.push_back(wbank);
        wbank = ~wbank;
      end else begin
        open_q.push_back({1'b0, d});
      end
    end
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("out_last", out_last, m_ol);
    check("out", out, m_out);
  endtask

  // Feed src_q until everything has come out. bmode: 0 idle consumer,
  // 1 stalled for the first 12 cycles, 2 busy toggling, 3 random.
  task automatic run(input int bmode, input int max_cyc);
    bit acc, v, b, done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (src_q.size() == 0 && ready_q.size() == 0 && open_q.size() == 0 && !m_ov) begin
        done = 1'b1;
        break;
      end
      case (bmode)
        1:       b = (i < 12);
        2:       b = i[0];
        3:       b = ($urandom_range(0, 9) < 4);
        default: b = 1'b0;
      endcase
      v = (src_q.size() > 0) && (bmode != 3 || $urandom_range(0, 3) != 0);
      if (src_q.size() > 0) cycle(v, src_q[0][7:0], src_q[0][8], b, acc);
      else                  cycle(1'b0, 8'h00, 1'b0, b, acc);
      if (acc) void'(src_q.pop_front());
    end
    check("drain_done", done, 1'b1);
  endtask

  initial begin
    bit acc;
    int n_acc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    busy     = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 8'h00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_bank_full", bank_full, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous stream, two natural fills.
    for (int i = 0; i < 8; i++) src_q.push_back({1'b0, 8'(8'h10 + i)});
    run(0, 60);

    // Stalled consumer: both banks fill, ninth word waits.
    for (int i = 0; i < 9; i++) src_q.push_back({(i == 8), 8'(8'h20 + i)});
    run(1, 80);

    // Early close after two words, then a full bank.
    src_q.push_back({1'b0, 8'hA1});
    src_q.push_back({1'b1, 8'hA2});
    for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 8'(8'hB0 + i)});
    run(0, 60);

    // Busy toggling every other cycle.
    for (int i = 0; i < 10; i++) src_q.push_back({(i == 9), 8'(8'hC0 + i)});
    run(2, 100);

    // Async reset mid-drain.
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 8; i++) begin
      cycle(1'b1, 8'(8'h30 + n_acc), 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("pending_before_reset", ready_q.size() > 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out_last", out_last, 1'b0);
    check("async_out", out, 8'h00);
    check("async_bank_full", bank_full, 2'b00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Single-word banks after reset: first goes to bank 0, next to bank 1.
    src_q.push_back({1'b1, 8'h5C});
    src_q.push_back({1'b1, 8'h6D});
    run(0, 40);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      src_q.push_back({(i == 149) || ($urandom_range(0, 7) == 0), 8'($urandom)});
    end
    run(3, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pp_buffer_gen.md
Name: pp_buffer_gen

Overview:
- Parametrised two-bank ping-pong buffer between a streaming producer and a back-pressured consumer.
- Writer fills one bank while the reader drains the other. Banks swap only when a bank is closed by the writer and fully drained by the reader.
- Adds over the previous generation: configurable width and depth, input back-pressure (no overwrite), early bank close via in_last with per-bank length, registered output with valid/busy handshake, and end-of-bank marker.

Parameters:
DATA_W  8   data word width in bits
DEPTH   64  words per bank; must be >= 2
ADDR_W  $clog2(DEPTH)  derived local parameter; not overridable

Ports:
clk        input   1          rising-edge clock; the only clock
rst_n      input   1          asynchronous active-low reset
in_valid   input   1          producer has a word on in
in_ready   output  1          buffer can accept a word this cycle
in         input   DATA_W     write data
in_last    input   1          qualifies in; closes the current bank after this word
out_valid  output  1          out holds a valid word
busy       input   1          consumer stall; out must hold while out_valid && busy
out        output  DATA_W     read data, registered
out_last   output  1          out is the final word of its bank
bank_full  output  2          per-bank closed/readable flag; bit i = bank i

Behaviour:
- Interface: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values: out_valid=0, out=0, out_last=0, bank_full=2'b00. Internal wsel=0, rsel=0, waddr=0, raddr=0, len[0]=len[1]=0.
- Reset mid-operation discards all buffered data; stored memory contents need not be cleared.
- in_ready = ~bank_full[wsel] (combinational from state). It does not depend on in_valid.
- Write accept = in_valid && in_ready. On accept:
  - mem[wsel][waddr] <= in.
  - If waddr==DEPTH-1 or in_last: len[wsel] <= waddr+1 (ADDR_W+1 bits), bank_full[wsel] <= 1, waddr <= 0, wsel toggles.
  - Otherwise waddr increments.
- in_valid while in_ready=0: no write, no state change. The producer must hold the word.
- Read advance condition: bank_full[rsel] && (~out_valid || ~busy). On advance:
  - out <= mem[rsel][raddr], out_valid <= 1, out_last <= (raddr == len[rsel]-1).
  - If last: bank_full[rsel] <= 0, raddr <= 0, rsel toggles. Otherwise raddr increments.
- No data (bank_full[rsel]=0) and (~out_valid || ~busy): out_valid <= 0, out_last <= 0. out holds its last value.
- out_valid && busy: out, out_valid and out_last hold unchanged.
- Latency: the edge that closes a bank sets bank_full. If the reader is idle, out_valid rises on the next edge. First word out is 1 cycle after close, throughput 1 word/cycle while busy=0.
- Simultaneous set/clear on one bank is impossible:
  - The writer sets bank_full only on a non-full bank.
  - The reader clears it only on a full bank.
  - Set on bank A and clear on bank B in the same cycle are both honoured.
- Both banks full: in_ready=0 until the reader frees a bank. Freeing happens on the edge that reads the bank's last word; in_ready rises in the following cycle.
- in_last on the first word of a bank gives a length-1 bank; that single word has out_last=1.
- in_last on word DEPTH-1 behaves identically to a natural fill.
- Data order out equals accept order in. No word is ever dropped or duplicated.
- Pointers wrap to 0 only on bank close or drain. waddr and raddr never exceed DEPTH-1.

Test Plan:
1. DEPTH=4, DATA_W=8, busy=0. Stream 8 words 0x10..0x17 continuously.
   - Required: out shows 0x10..0x17 in order.
   - out_last=1 on 0x13 and 0x17; in_ready stays 1 throughout.
   - First out_valid is 1 cycle after the edge accepting 0x13.
2. DEPTH=4, busy=1 held. Push 9 words.
   - Required: in_ready drops after the 8th accept; bank_full=2'b11; the 9th word is held un-accepted.
   - Release busy: in_ready returns the cycle after 0x..3 is read; all 9 words emerge in order.
3. in_last on the 2nd word (0xA1, 0xA2), then 4 words 0xB0..0xB3 with DEPTH=4.
   - Required: out_last on 0xA2 and 0xB3.
   - Bank lengths are 2 and 4; no stale data is emitted.
4. Toggle busy every other cycle while out_valid=1.
   - Required: out/out_last are stable across every busy=1 cycle; no duplicate or skipped words.
5. Assert rst_n=0 asynchronously mid-drain with 3 words pending.
   - Required: out_valid, out_last, out and bank_full go 0 immediately, without waiting for a clk edge.
   - After release, the first new write lands in bank 0 and the old words never appear.
6. in_last on the first word (0x5C).
   - Required: a single-word bank; out=0x5C with out_last=1; the next write goes to the other bank.
